// File: rtl/hazard_unit.sv
// Pipeline interlock for the 5-stage MIPS core: load-use, branch-in-ID operand and HI/LO mult/div tracking.
// Define HAZARD_PERF_EN to add the stall-cycle and flush performance counters.
module hazard_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_branch_taken,
  input  logic       id_md_start,
  input  logic       id_md_is_div,
  input  logic       id_reads_hilo,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_write_reg,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flushes
`endif
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic rs_ex_match, rt_ex_match, rs_mem_match, rt_mem_match;
  logic ex_match, mem_match;
  logic load_use, br_haz, md_haz, stall;

  // Register $0 is hardwired to zero, so it can never carry a dependency.
  always_comb begin
    rs_ex_match  = id_uses_rs && (id_rs != 5'd0) && (id_rs == ex_write_reg);
    rt_ex_match  = id_uses_rt && (id_rt != 5'd0) && (id_rt == ex_write_reg);
    rs_mem_match = id_uses_rs && (id_rs != 5'd0) && (id_rs == mem_write_reg);
    rt_mem_match = id_uses_rt && (id_rt != 5'd0) && (id_rt == mem_write_reg);
    ex_match     = rs_ex_match || rt_ex_match;
    mem_match    = rs_mem_match || rt_mem_match;

    load_use = ex_mem_read && ex_match;
    br_haz   = id_is_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    md_haz   = md_busy && (id_reads_hilo || id_md_start);
    stall    = load_use || br_haz || md_haz;
  end

  always_comb begin
    pc_write     = !stall;
    if_id_write  = !stall;
    id_ex_bubble = stall;
    // A stalled branch may see different operands next cycle, so it must not flush yet.
    if_id_flush  = id_branch_taken && !stall;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (id_md_start && !stall) begin
          state_next = BUSY;
          cnt_next   = id_md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          cnt_next = cnt - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = (state == BUSY);
    md_done = (state == BUSY) && (cnt == '0);
  end

`ifdef HAZARD_PERF_EN
  // Both counters wrap naturally at their width.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (stall)       perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (if_id_flush) perf_flushes      <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; control outputs are compared as one packed vector
// {pc_write, if_id_write, id_ex_bubble, if_id_flush, md_busy, md_done}.
module tb_hazard_unit;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic       id_is_branch, id_branch_taken;
  logic       id_md_start, id_md_is_div, id_reads_hilo;
  logic       ex_reg_write, ex_mem_read;
  logic [4:0] ex_write_reg;
  logic       mem_mem_read;
  logic [4:0] mem_write_reg;
  logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, md_busy, md_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  logic [5:0] ctrl;
  assign ctrl = {pc_write, if_id_write, id_ex_bubble, if_id_flush, md_busy, md_done};

  localparam logic [5:0] RUN       = 6'b110000;
  localparam logic [5:0] STALL     = 6'b001000;
  localparam logic [5:0] FLUSH     = 6'b110100;
  localparam logic [5:0] BUSY_RUN  = 6'b110010;
  localparam logic [5:0] BUSY_STL  = 6'b001010;
  localparam logic [5:0] DONE_RUN  = 6'b110011;
  localparam logic [5:0] DONE_STL  = 6'b001011;

  int vectors = 0;
  int miscompares = 0;

  hazard_unit #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_branch    (id_is_branch),
    .id_branch_taken (id_branch_taken),
    .id_md_start     (id_md_start),
    .id_md_is_div    (id_md_is_div),
    .id_reads_hilo   (id_reads_hilo),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_write_reg    (ex_write_reg),
    .mem_mem_read    (mem_mem_read),
    .mem_write_reg   (mem_write_reg),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_bubble    (id_ex_bubble),
    .if_id_flush     (if_id_flush),
    .md_busy         (md_busy),
    .md_done         (md_done)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge; inputs change here, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; id_branch_taken = 1'b0;
    id_md_start = 1'b0; id_md_is_div = 1'b0; id_reads_hilo = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_write_reg = 5'd0;
    mem_mem_read = 1'b0; mem_write_reg = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL reset_state: got %b want %b", ctrl, RUN); miscompares++;
    end
`ifdef HAZARD_PERF_EN
    vectors++;
    if (perf_stall_cycles !== 32'd0 || perf_flushes !== 16'd0) begin
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_stall_cycles, perf_flushes); miscompares++;
    end
`endif
  endtask

  task automatic test_load_use();
    logic [5:0] want [6];
    tick(); clear_inputs();
    // lw $t0 in EX, add in ID reads rs=$t0
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd8;
    for (int v = 0; v < 6; v++) begin
      id_rs = 5'd8; id_rt = 5'd3; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
      ex_write_reg = 5'd8; ex_mem_read = 1'b1;
      case (v)
        0: want[v] = STALL;                                        // rs match
        1: begin id_rs = 5'd3; id_rt = 5'd8; want[v] = STALL; end  // rt match
        2: begin id_uses_rs = 1'b0; want[v] = RUN; end             // rs not read
        3: begin id_rs = 5'd0; ex_write_reg = 5'd0; want[v] = RUN; end // $0
        4: begin ex_mem_read = 1'b0; want[v] = RUN; end            // ALU producer forwards
        default: begin id_rs = 5'd9; want[v] = RUN; end            // no match
      endcase
      #1;
      vectors++;
      if (ctrl !== want[v]) begin
        $display("FAIL load_use_%0d: got %b want %b", v, ctrl, want[v]); miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_branch_ex();
    clear_inputs();
    // beq rs=9 in ID, EX add writes 9, branch taken
    id_is_branch = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1; id_branch_taken = 1'b1;
    ex_reg_write = 1'b1; ex_write_reg = 5'd9;
    #1;
    vectors++;
    if (ctrl !== STALL) begin
      $display("FAIL branch_ex_stall: got %b want %b", ctrl, STALL); miscompares++;
    end
    tick();
    ex_reg_write = 1'b0; ex_write_reg = 5'd0;
    mem_write_reg = 5'd9; mem_mem_read = 1'b0;
    #1;
    vectors++;
    if (ctrl !== FLUSH) begin
      $display("FAIL branch_ex_flush: got %b want %b", ctrl, FLUSH); miscompares++;
    end
    tick();
  endtask

  task automatic test_branch_load();
    clear_inputs();
    // beq rt=10 in ID, lw writes 10 in EX; two stall cycles then flush
    id_is_branch = 1'b1; id_rt = 5'd10; id_uses_rt = 1'b1; id_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_write_reg = 5'd10;
    #1;
    vectors++;
    if (ctrl !== STALL) begin
      $display("FAIL branch_load_stall1: got %b want %b", ctrl, STALL); miscompares++;
    end
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_write_reg = 5'd0;
    mem_mem_read = 1'b1; mem_write_reg = 5'd10;
    #1;
    vectors++;
    if (ctrl !== STALL) begin
      $display("FAIL branch_load_stall2: got %b want %b", ctrl, STALL); miscompares++;
    end
    tick();
    mem_mem_read = 1'b0; mem_write_reg = 5'd0;
    #1;
    vectors++;
    if (ctrl !== FLUSH) begin
      $display("FAIL branch_load_flush: got %b want %b", ctrl, FLUSH); miscompares++;
    end
    tick();
    // A non-branch reading a MEM-stage load result is forwarded, not stalled
    clear_inputs();
    id_rs = 5'd10; id_uses_rs = 1'b1; mem_mem_read = 1'b1; mem_write_reg = 5'd10;
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL nonbranch_mem_load: got %b want %b", ctrl, RUN); miscompares++;
    end
    tick();
  endtask

  task automatic test_div_mfhi();
    logic [5:0] want;
    clear_inputs();
    id_md_start = 1'b1; id_md_is_div = 1'b1;
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL div_issue: got %b want %b", ctrl, RUN); miscompares++;
    end
    tick();
    clear_inputs();
    id_reads_hilo = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      want = (k == 32) ? DONE_STL : BUSY_STL;
      #1;
      vectors++;
      if (ctrl !== want) begin
        $display("FAIL div_busy_cycle_%0d: got %b want %b", k, ctrl, want); miscompares++;
      end
      tick();
    end
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL div_mfhi_proceeds: got %b want %b", ctrl, RUN); miscompares++;
    end
    tick();
  endtask

  task automatic test_mult_reset();
    clear_inputs();
    id_md_start = 1'b1;
    tick();
    clear_inputs();
    id_reads_hilo = 1'b1;
    #1;
    vectors++;
    if (ctrl !== BUSY_STL) begin
      $display("FAIL mult_busy1: got %b want %b", ctrl, BUSY_STL); miscompares++;
    end
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (ctrl !== BUSY_STL) begin
      $display("FAIL mult_busy2_reset_pending: got %b want %b", ctrl, BUSY_STL); miscompares++;
    end
    tick();
    reset = 1'b0;
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL mult_after_reset: got %b want %b", ctrl, RUN); miscompares++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] want;
    clear_inputs();
    id_md_start = 1'b1;
    tick();
    // second mult waits in ID for the whole first operation
    for (int k = 1; k <= 4; k++) begin
      want = (k == 4) ? DONE_STL : BUSY_STL;
      #1;
      vectors++;
      if (ctrl !== want) begin
        $display("FAIL b2b_first_cycle_%0d: got %b want %b", k, ctrl, want); miscompares++;
      end
      tick();
    end
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL b2b_second_issue: got %b want %b", ctrl, RUN); miscompares++;
    end
    tick();
    clear_inputs();
    for (int k = 1; k <= 5; k++) begin
      want = (k == 5) ? RUN : ((k == 4) ? DONE_RUN : BUSY_RUN);
      #1;
      vectors++;
      if (ctrl !== want) begin
        $display("FAIL b2b_second_cycle_%0d: got %b want %b", k, ctrl, want); miscompares++;
      end
      tick();
    end
  endtask

  task automatic test_start_blocked();
    clear_inputs();
    // mult in ID also stalled by a load-use: start must not be taken
    id_md_start = 1'b1; id_rs = 5'd4; id_uses_rs = 1'b1;
    ex_mem_read = 1'b1; ex_write_reg = 5'd4;
    #1;
    vectors++;
    if (ctrl !== STALL) begin
      $display("FAIL blocked_start_stall: got %b want %b", ctrl, STALL); miscompares++;
    end
    tick();
    ex_mem_read = 1'b0; ex_write_reg = 5'd0;
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL blocked_start_not_taken: got %b want %b", ctrl, RUN); miscompares++;
    end
    tick();
    clear_inputs();
    #1;
    vectors++;
    if (ctrl !== BUSY_RUN) begin
      $display("FAIL blocked_start_resampled: got %b want %b", ctrl, BUSY_RUN); miscompares++;
    end
    for (int k = 0; k < 4; k++) tick();
    #1;
    vectors++;
    if (ctrl !== RUN) begin
      $display("FAIL blocked_start_complete: got %b want %b", ctrl, RUN); miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_ex();
    test_branch_load();
    test_div_mfhi();
    test_mult_reset();
    test_back_to_back();
    test_start_blocked();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
